window_gen_3x3: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the stage-1 convolution. It accepts a raster-order binary pixel stream, buffers the two previous image rows, and presents each complete 3x3 neighbourhood on nine 1-bit outputs. The outputs map one-to-one onto the convolution's `in1`..`in9`. Only windows lying fully inside the image are flagged valid, with no border padding.

---
 rtl/window_gen_3x3_pkg.sv | 20 ++
 rtl/window_gen_3x3_if.sv | 39 +++
 rtl/window_gen_3x3_line_buffer.sv | 30 +++
 rtl/window_gen_3x3.sv | 185 ++++++++++++++++++
 tb/tb_window_gen_3x3.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/window_gen_3x3_pkg.sv
// Shared types and constants for the 3x3 streaming window generator.
// Window indices follow row-major order: top-left = 1, centre = 5, bottom-right = 9.
package wingen_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned WIN_TL = 1;
    localparam int unsigned WIN_TM = 2;
    localparam int unsigned WIN_TR = 3;
    localparam int unsigned WIN_ML = 4;
    localparam int unsigned WIN_MM = 5;
    localparam int unsigned WIN_MR = 6;
    localparam int unsigned WIN_BL = 7;
    localparam int unsigned WIN_BM = 8;
    localparam int unsigned WIN_BR = 9;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-stream in / 3x3 window out bundle; frame_done exists only with WINGEN_FRAME_DONE_EN.
interface window_gen_3x3_if;

    logic sof;
    logic pix_valid;
    logic pix_in;
    logic win1;
    logic win2;
    logic win3;
    logic win4;
    logic win5;
    logic win6;
    logic win7;
    logic win8;
    logic win9;
    logic win_valid;
`ifdef WINGEN_FRAME_DONE_EN
    logic frame_done;
`endif

    modport master (
        output sof, pix_valid, pix_in,
        input  win1, win2, win3, win4, win5, win6, win7, win8, win9,
        input  win_valid
`ifdef WINGEN_FRAME_DONE_EN
        , input frame_done
`endif
    );

    modport slave (
        input  sof, pix_valid, pix_in,
        output win1, win2, win3, win4, win5, win6, win7, win8, win9,
        output win_valid
`ifdef WINGEN_FRAME_DONE_EN
        , output frame_done
`endif
    );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One-bit, DEPTH-deep row delay line: the addressed bit is read combinationally
// (old contents) while the same address is overwritten on the enabled edge.
module line_buffer
    import wingen_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          wr_data,
    output logic          rd_data
);

    logic [DEPTH-1:0] mem_r;

    assign rd_data = mem_r[addr];

    // Storage bits, cleared by reset so stale data is deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= {DEPTH{1'b0}};
        end else if (we) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator over a binary raster stream (two row buffers + 3x3 shift window).
// Optional build macro WINGEN_FRAME_DONE_EN adds the frame_done pulse.
module window_gen_3x3
    import wingen_pkg::*;
#(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    window_gen_3x3_if.slave    bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [COL_W-1:0]   col_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_cur_s;
    logic [ROW_W-1:0]   row_cur_s;
    logic [COL_W-1:0]   col_nxt_s;
    logic [ROW_W-1:0]   row_nxt_s;
    logic               accept_s;
    logic               last_pix_s;
    logic               win_ok_s;
    logic               top_s;
    logic               mid_s;
    logic [WIN_BR:WIN_TL] win_r;
    logic               win_valid_r;

    // Acceptance and the position of the pixel being accepted; sof forces (0,0).
    always_comb begin
        accept_s  = 1'b0;
        col_cur_s = col_r;
        row_cur_s = row_r;
        if (bus.pix_valid && bus.sof) begin
            accept_s  = 1'b1;
            col_cur_s = {COL_W{1'b0}};
            row_cur_s = {ROW_W{1'b0}};
        end else if (bus.pix_valid && (state_r == ST_RUN)) begin
            accept_s  = 1'b1;
        end else begin
            accept_s  = 1'b0;
        end
        last_pix_s = (row_cur_s == ROW_LAST) && (col_cur_s == COL_LAST);
        win_ok_s   = accept_s && (row_cur_s >= ROW_TWO) && (col_cur_s >= COL_TWO);
    end

    // Raster counters for the next accepted pixel.
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (accept_s) begin
            if (col_cur_s == COL_LAST) begin
                col_nxt_s = {COL_W{1'b0}};
                if (row_cur_s == ROW_LAST) begin
                    row_nxt_s = {ROW_W{1'b0}};
                end else begin
                    row_nxt_s = row_cur_s + ROW_W'(1);
                end
            end else begin
                col_nxt_s = col_cur_s + COL_W'(1);
                row_nxt_s = row_cur_s;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Frame state: leaves RUN only after the bottom-right pixel is accepted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.pix_valid && bus.sof) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_pix_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
        end
    end

    line_buffer #(.DEPTH(IMG_W)) u_l1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept_s),
        .addr    (col_cur_s),
        .wr_data (bus.pix_in),
        .rd_data (mid_s)
    );

    line_buffer #(.DEPTH(IMG_W)) u_l2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept_s),
        .addr    (col_cur_s),
        .wr_data (mid_s),
        .rd_data (top_s)
    );

    // Window shift register: columns move left, new right column is (L2, L1, pixel).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r <= 9'b0;
        end else if (accept_s) begin
            win_r[WIN_TL] <= win_r[WIN_TM];
            win_r[WIN_TM] <= win_r[WIN_TR];
            win_r[WIN_TR] <= top_s;
            win_r[WIN_ML] <= win_r[WIN_MM];
            win_r[WIN_MM] <= win_r[WIN_MR];
            win_r[WIN_MR] <= mid_s;
            win_r[WIN_BL] <= win_r[WIN_BM];
            win_r[WIN_BM] <= win_r[WIN_BR];
            win_r[WIN_BR] <= bus.pix_in;
        end
    end

    // Single-cycle valid for fully in-image windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_r <= 1'b0;
        end else begin
            win_valid_r <= win_ok_s;
        end
    end

    assign bus.win1      = win_r[WIN_TL];
    assign bus.win2      = win_r[WIN_TM];
    assign bus.win3      = win_r[WIN_TR];
    assign bus.win4      = win_r[WIN_ML];
    assign bus.win5      = win_r[WIN_MM];
    assign bus.win6      = win_r[WIN_MR];
    assign bus.win7      = win_r[WIN_BL];
    assign bus.win8      = win_r[WIN_BM];
    assign bus.win9      = win_r[WIN_BR];
    assign bus.win_valid = win_valid_r;

`ifdef WINGEN_FRAME_DONE_EN
    logic frame_done_r;

    // Pulse alongside the window completed by the bottom-right pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= accept_s && last_pix_s;
        end
    end

    assign bus.frame_done = frame_done_r;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed self-checking bench for window_gen_3x3 on a 4x4 image.
module tb_window_gen_3x3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic       obs_valid;
    logic [8:0] obs_win;
`ifdef WINGEN_FRAME_DONE_EN
    logic       obs_fd;
`endif

    window_gen_3x3_if bus();

    window_gen_3x3 #(.IMG_W(4), .IMG_H(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic sample();
        obs_valid = bus.win_valid;
        obs_win   = {bus.win1, bus.win2, bus.win3, bus.win4, bus.win5,
                     bus.win6, bus.win7, bus.win8, bus.win9};
`ifdef WINGEN_FRAME_DONE_EN
        obs_fd    = bus.frame_done;
`endif
    endtask

    task automatic drive_cycle(input logic v, input logic s, input logic p);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        @(posedge clk);
        #1;
        sample();
    endtask

    // Full 4x4 frame starting with sof; exp_wins holds the four windows in order, first in the MSBs.
    task automatic run_frame(input string name, input logic [15:0] img,
                             input logic gapped, input logic [35:0] exp_wins);
        int   k;
        logic exp_v;
        logic [8:0] exp_w;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, (i == 0), img[i]);
            exp_v = ((i / 4) >= 2) && ((i % 4) >= 2);
            checks++;
            if (obs_valid !== exp_v) begin
                failures++;
                $display("FAIL %s_valid idx=%0d got=%b exp=%b", name, i, obs_valid, exp_v);
            end
            if (exp_v) begin
                exp_w = exp_wins[35 - 9*k -: 9];
                checks++;
                if (obs_win !== exp_w) begin
                    failures++;
                    $display("FAIL %s_win idx=%0d got=%b exp=%b", name, i, obs_win, exp_w);
                end
                k++;
            end
`ifdef WINGEN_FRAME_DONE_EN
            checks++;
            if (obs_fd !== (i == 15)) begin
                failures++;
                $display("FAIL %s_frame_done idx=%0d got=%b exp=%b", name, i, obs_fd, (i == 15));
            end
`endif
            if (gapped) begin
                drive_cycle(1'b0, 1'b0, 1'b1);
                checks++;
                if (obs_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_gap_valid idx=%0d got=%b exp=0", name, i, obs_valid);
                end
            end
        end
    endtask

    localparam logic [35:0] ONES_WINS   = {4{9'h1FF}};
    localparam logic [35:0] SINGLE_WINS = {9'b000010000, 9'b000100000,
                                           9'b010000000, 9'b100000000};

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            checks++;
            if ({obs_valid, obs_win} !== 10'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=0", i, {obs_valid, obs_win});
            end
        end
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignore cyc=%0d got=%b exp=0", i, obs_valid);
            end
        end
    endtask

    task automatic test_mid_sof();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b1, (i == 0), 1'b1);
            checks++;
            if (obs_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_sof_pre idx=%0d got=%b exp=0", i, obs_valid);
            end
        end
        run_frame("mid_sof", 16'h0020, 1'b0, SINGLE_WINS);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 11; i++) begin
            drive_cycle(1'b1, (i == 0), 1'b1);
        end
        checks++;
        if (obs_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_valid got=%b exp=1", obs_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        checks++;
        if ({obs_valid, obs_win} !== 10'b0) begin
            failures++;
            $display("FAIL areset_immediate got=%b exp=0", {obs_valid, obs_win});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_valid !== 1'b0) begin
                failures++;
                $display("FAIL areset_ignore cyc=%0d got=%b exp=0", i, obs_valid);
            end
        end
        run_frame("areset_recover", 16'hFFFF, 1'b0, ONES_WINS);
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = 1'b0;
        test_reset();
        run_frame("all_ones", 16'hFFFF, 1'b0, ONES_WINS);
        test_idle_ignore();
        run_frame("single_one", 16'h0020, 1'b0, SINGLE_WINS);
        run_frame("gapped", 16'h0020, 1'b1, SINGLE_WINS);
        test_mid_sof();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
